// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter (with internal ALU sub-module alu_arbiter_alu)
//  Purpose  : Shares one 8-bit ALU between two requesters. Round-robin
//             arbitration in IDLE, one execute cycle, then a registered
//             result held on a valid/ready response channel until consumed.
//  Ports    : clk_i, rst_n_i         clock / async active-low reset
//             reqN_vld_i/rdy_o       request handshake, requester N (0/1)
//             reqN_a_i/b_i/op_i      operands and opcode
//             rspN_vld_o/rdy_i       response handshake, requester N
//             rsp_s_o, rsp_c_o       shared result byte and carry
//             busy_o                 high while an operation is in flight
//             ops_cnt_o              completed-response counter (wraps)
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  alu_arbiter_alu : combinational 8-bit ALU
//  op 00 add, 01 sub, 10 decrement a, 11 xor
// ----------------------------------------------------------------------------
module alu_arbiter_alu (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [1:0] op_i,
    output logic [7:0] s_o,
    output logic       c_o
);
    logic [8:0] sum;
    logic [8:0] dif;

    assign sum = {1'b0, a_i} + {1'b0, b_i};
    // Bit 8 of the 9-bit difference is the borrow: set when a < b.
    assign dif = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        s_o = 8'h00;
        c_o = 1'b0;
        case (op_i)
            2'b00: begin
                s_o = sum[7:0];
                c_o = sum[8];
            end
            2'b01: begin
                s_o = dif[7:0];
                c_o = dif[8];
            end
            2'b10: s_o = a_i - 8'd1;
            default: s_o = a_i ^ b_i;
        endcase
    end
endmodule

// ----------------------------------------------------------------------------
//  alu_arbiter : top level
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req0_vld_i,
    output logic             req0_rdy_o,
    input  logic [7:0]       req0_a_i,
    input  logic [7:0]       req0_b_i,
    input  logic [1:0]       req0_op_i,
    input  logic             req1_vld_i,
    output logic             req1_rdy_o,
    input  logic [7:0]       req1_a_i,
    input  logic [7:0]       req1_b_i,
    input  logic [1:0]       req1_op_i,
    output logic             rsp0_vld_o,
    input  logic             rsp0_rdy_i,
    output logic             rsp1_vld_o,
    input  logic             rsp1_rdy_i,
    output logic [7:0]       rsp_s_o,
    output logic             rsp_c_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] ops_cnt_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q;
    logic             rr_last_q;   // id granted most recently (1 => req0 wins next tie)
    logic             gnt_id_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [1:0]       op_q;
    logic [7:0]       s_q;
    logic             c_q;
    logic             rsp0_vld_q;
    logic             rsp1_vld_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic             in_idle;
    logic             pick0;
    logic             pick1;
    logic             take;
    logic             rsp_done;
    logic [7:0]       alu_s;
    logic             alu_c;

    assign in_idle = (state_q == ST_IDLE);

    // Round-robin: a lone requester always wins; on a tie the one not
    // granted last time wins.
    assign pick0 = req0_vld_i & (~req1_vld_i | rr_last_q);
    assign pick1 = req1_vld_i & (~req0_vld_i | ~rr_last_q);

    // rst_n_i gating keeps rdy low while reset is asserted even though the
    // FSM sits in IDLE then.
    assign req0_rdy_o = rst_n_i & in_idle & pick0;
    assign req1_rdy_o = rst_n_i & in_idle & pick1;
    assign take       = req0_rdy_o | req1_rdy_o;

    // Only the granted channel's vld is ever high, so the other rdy is
    // naturally ignored.
    assign rsp_done = (rsp0_vld_q & rsp0_rdy_i) | (rsp1_vld_q & rsp1_rdy_i);

    alu_arbiter_alu u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .s_o  (alu_s),
        .c_o  (alu_c)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= 1'b1;
            gnt_id_q   <= 1'b0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            op_q       <= 2'b00;
            s_q        <= 8'h00;
            c_q        <= 1'b0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        a_q      <= req1_rdy_o ? req1_a_i  : req0_a_i;
                        b_q      <= req1_rdy_o ? req1_b_i  : req0_b_i;
                        op_q     <= req1_rdy_o ? req1_op_i : req0_op_i;
                        gnt_id_q <= req1_rdy_o;
                        busy_q   <= 1'b1;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    s_q        <= alu_s;
                    c_q        <= alu_c;
                    rsp0_vld_q <= ~gnt_id_q;
                    rsp1_vld_q <= gnt_id_q;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_done) begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        rr_last_q  <= gnt_id_q;
                        rsp0_vld_q <= 1'b0;
                        rsp1_vld_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp0_vld_o = rsp0_vld_q;
    assign rsp1_vld_o = rsp1_vld_q;
    assign rsp_s_o    = s_q;
    assign rsp_c_o    = c_q;
    assign busy_o     = busy_q;
    assign ops_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. A transaction-level model
//             (pending-operation queue with an age count) predicts every
//             output each cycle; directed table vectors and hand-written
//             sequences cover the corner cases. A second instance with a
//             2-bit counter shares all inputs to exercise counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_vld, req1_vld, rsp0_rdy, rsp1_rdy;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;

    logic        req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_c, busy;
    logic [7:0]  rsp_s;
    logic [15:0] cnt;

    logic        n_req0_rdy, n_req1_rdy, n_rsp0_vld, n_rsp1_vld, n_rsp_c, n_busy;
    logic [7:0]  n_rsp_s;
    logic [1:0]  n_cnt;

    alu_arbiter #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_vld_i(req0_vld), .req0_rdy_o(req0_rdy), .req0_a_i(req0_a),
        .req0_b_i(req0_b), .req0_op_i(req0_op),
        .req1_vld_i(req1_vld), .req1_rdy_o(req1_rdy), .req1_a_i(req1_a),
        .req1_b_i(req1_b), .req1_op_i(req1_op),
        .rsp0_vld_o(rsp0_vld), .rsp0_rdy_i(rsp0_rdy),
        .rsp1_vld_o(rsp1_vld), .rsp1_rdy_i(rsp1_rdy),
        .rsp_s_o(rsp_s), .rsp_c_o(rsp_c), .busy_o(busy), .ops_cnt_o(cnt)
    );

    alu_arbiter #(.CNT_W(2)) dut_w2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_vld_i(req0_vld), .req0_rdy_o(n_req0_rdy), .req0_a_i(req0_a),
        .req0_b_i(req0_b), .req0_op_i(req0_op),
        .req1_vld_i(req1_vld), .req1_rdy_o(n_req1_rdy), .req1_a_i(req1_a),
        .req1_b_i(req1_b), .req1_op_i(req1_op),
        .rsp0_vld_o(n_rsp0_vld), .rsp0_rdy_i(rsp0_rdy),
        .rsp1_vld_o(n_rsp1_vld), .rsp1_rdy_i(rsp1_rdy),
        .rsp_s_o(n_rsp_s), .rsp_c_o(n_rsp_c), .busy_o(n_busy), .ops_cnt_o(n_cnt)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue holding at most one accepted operation.
    // age 0 = accepted last edge (result not yet visible), age 1 = result
    // visible and waiting to be consumed.
    // ------------------------------------------------------------------
    typedef struct {
        bit         id;
        logic [7:0] s;
        bit         c;
        int         age;
    } txn_t;

    txn_t        mq[$];
    bit          m_last;
    int unsigned m_cnt;
    logic [7:0]  m_s;
    bit          m_c;

    function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b,
                                    input logic [1:0] op,
                                    output logic [7:0] s, output bit c);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        c  = 1'b0;
        case (op)
            2'd0: begin r = ai + bi; c = (r > 255); end
            2'd1: begin r = ai - bi; c = (ai < bi); end
            2'd2: begin r = ai - 1; end
            default: begin r = ai ^ bi; end
        endcase
        s = r[7:0];
    endfunction

    function automatic bit exp_rdy(input bit id);
        bit winner;
        if (!rst_n || mq.size() != 0) return 1'b0;
        if (req0_vld && req1_vld) begin
            winner = !m_last;
            return id == winner;
        end
        return id ? req1_vld : req0_vld;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last = 1'b1;
        m_cnt  = 0;
        m_s    = 8'h00;
        m_c    = 1'b0;
    endtask

    task automatic model_update();
        txn_t t;
        bit   g0, g1;
        if (!rst_n) return;
        if (mq.size() != 0) begin
            if (mq[0].age >= 1) begin
                if (mq[0].id ? rsp1_rdy : rsp0_rdy) begin
                    m_last = mq[0].id;
                    m_cnt++;
                    void'(mq.pop_front());
                end
            end else begin
                mq[0].age = 1;
                m_s = mq[0].s;
                m_c = mq[0].c;
            end
        end else begin
            g0 = exp_rdy(1'b0);
            g1 = exp_rdy(1'b1);
            if (g0 || g1) begin
                t.id  = g1;
                t.age = 0;
                if (g1) ref_alu(req1_a, req1_b, req1_op, t.s, t.c);
                else    ref_alu(req0_a, req0_b, req0_op, t.s, t.c);
                mq.push_back(t);
            end
        end
    endtask

    task automatic check_all();
        bit v0, v1;
        if (!rst_n) model_reset();
        v0 = (mq.size() != 0) && (mq[0].age >= 1) && (mq[0].id == 1'b0);
        v1 = (mq.size() != 0) && (mq[0].age >= 1) && (mq[0].id == 1'b1);
        chk("req0_rdy", {31'd0, req0_rdy}, {31'd0, exp_rdy(1'b0)});
        chk("req1_rdy", {31'd0, req1_rdy}, {31'd0, exp_rdy(1'b1)});
        chk("rsp0_vld", {31'd0, rsp0_vld}, {31'd0, v0});
        chk("rsp1_vld", {31'd0, rsp1_vld}, {31'd0, v1});
        chk("rsp_s",    {24'd0, rsp_s},    {24'd0, m_s});
        chk("rsp_c",    {31'd0, rsp_c},    {31'd0, m_c});
        chk("busy",     {31'd0, busy},     {31'd0, (mq.size() != 0)});
        chk("ops_cnt",  {16'd0, cnt},      m_cnt & 32'hFFFF);
        chk("ops_cnt_w2", {30'd0, n_cnt},  m_cnt & 32'h3);
        chk("w2_rsp_s", {24'd0, n_rsp_s},  {24'd0, m_s});
    endtask

    // Observations from the DUT, recorded by cycle() for directed sequences.
    int         hs_log[$];
    int         rsp_log[$];
    logic       obs_v0, obs_v1, obs_c, obs_r1;
    logic [7:0] obs_s;

    // Called at the falling edge with inputs already driven.
    task automatic cycle();
        #1;
        check_all();
        obs_v0 = rsp0_vld;
        obs_v1 = rsp1_vld;
        obs_s  = rsp_s;
        obs_c  = rsp_c;
        obs_r1 = req1_rdy;
        if (req0_vld && req0_rdy) hs_log.push_back(0);
        if (req1_vld && req1_rdy) hs_log.push_back(1);
        if (rsp0_vld && rsp0_rdy) rsp_log.push_back(0);
        if (rsp1_vld && rsp1_rdy) rsp_log.push_back(1);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req0_rdy"}, {31'd0, req0_rdy}, 32'd0);
        chk({tag, "_req1_rdy"}, {31'd0, req1_rdy}, 32'd0);
        chk({tag, "_rsp0_vld"}, {31'd0, rsp0_vld}, 32'd0);
        chk({tag, "_rsp1_vld"}, {31'd0, rsp1_vld}, 32'd0);
        chk({tag, "_rsp_s"},    {24'd0, rsp_s},    32'd0);
        chk({tag, "_rsp_c"},    {31'd0, rsp_c},    32'd0);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_ops_cnt"},  {16'd0, cnt},      32'd0);
    endtask

    typedef struct {
        bit         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] s;
        bit         c;
    } vec_t;

    vec_t vt[8];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        int lat;
        int exp_order[4];

        vt[0] = '{1'b0, 8'hF0, 8'h20, 2'b00, 8'h10, 1'b1};
        vt[1] = '{1'b1, 8'h00, 8'h00, 2'b10, 8'hFF, 1'b0};
        vt[2] = '{1'b1, 8'hA5, 8'h0F, 2'b11, 8'hAA, 1'b0};
        vt[3] = '{1'b0, 8'h10, 8'h20, 2'b01, 8'hF0, 1'b1};
        vt[4] = '{1'b0, 8'h20, 8'h10, 2'b01, 8'h10, 1'b0};
        vt[5] = '{1'b1, 8'h01, 8'hFF, 2'b00, 8'h00, 1'b1};
        vt[6] = '{1'b0, 8'h00, 8'h55, 2'b10, 8'hFF, 1'b0};
        vt[7] = '{1'b1, 8'hFF, 8'hFF, 2'b11, 8'h00, 1'b0};

        rst_n = 1'b0;
        req0_vld = 0; req1_vld = 0; rsp0_rdy = 0; rsp1_rdy = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        model_reset();
        @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        cycle();

        // ---------------- table-driven single operations ----------------
        rsp0_rdy = 1; rsp1_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            hs_log.delete();
            if (vt[i].id) begin
                req1_vld = 1; req1_a = vt[i].a; req1_b = vt[i].b; req1_op = vt[i].op;
            end else begin
                req0_vld = 1; req0_a = vt[i].a; req0_b = vt[i].b; req0_op = vt[i].op;
            end
            t = 0;
            while (hs_log.size() == 0 && t < 10) begin
                cycle();
                t++;
            end
            chk("vec_accept", {31'd0, hs_log.size() == 1}, 32'd1);
            req0_vld = 0; req1_vld = 0;
            lat = 0;
            do begin
                cycle();
                lat++;
            end while (!(obs_v0 || obs_v1) && lat < 10);
            chk("vec_latency", lat, 2);
            chk("vec_rsp_id", {31'd0, obs_v1}, {31'd0, vt[i].id});
            chk("vec_s", {24'd0, obs_s}, {24'd0, vt[i].s});
            chk("vec_c", {31'd0, obs_c}, {31'd0, vt[i].c});
            chk("vec_ops_cnt", {16'd0, cnt}, i + 1);
            chk("vec_wrap_cnt", {30'd0, n_cnt}, (i + 1) % 4);
        end

        // ---------------- reset during EXEC ----------------
        hs_log.delete();
        req1_vld = 1; req1_a = 8'h12; req1_b = 8'h34; req1_op = 2'b00;
        t = 0;
        while (hs_log.size() == 0 && t < 10) begin
            cycle();
            t++;
        end
        chk("rst_accept", {31'd0, hs_log.size() == 1}, 32'd1);
        chk("rst_in_exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 0;
        req0_vld = 1; req1_vld = 1;
        #1;
        chk_reset_outputs("midop");
        cycle();
        cycle();
        rst_n = 1;

        // ---------------- contention from reset ----------------
        hs_log.delete();
        rsp_log.delete();
        req0_a = 8'h05; req0_b = 8'h03; req0_op = 2'b01;
        req1_a = 8'h07; req1_b = 8'h09; req1_op = 2'b00;
        t = 0;
        while (rsp_log.size() < 4 && t < 40) begin
            cycle();
            t++;
        end
        exp_order = '{0, 1, 0, 1};
        chk("cont_count", rsp_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_grant", (i < hs_log.size()) ? hs_log[i] : -1, exp_order[i]);
            chk("cont_rsp",   (i < rsp_log.size()) ? rsp_log[i] : -1, exp_order[i]);
        end
        req0_vld = 0; req1_vld = 0;
        cycle();

        // ---------------- response backpressure ----------------
        hs_log.delete();
        rsp0_rdy = 0; rsp1_rdy = 1;
        req0_vld = 1; req0_a = 8'h33; req0_b = 8'h44; req0_op = 2'b00;
        t = 0;
        while (hs_log.size() == 0 && t < 10) begin
            cycle();
            t++;
        end
        req0_vld = 0;
        req1_vld = 1; req1_a = 8'hC3; req1_b = 8'h3C; req1_op = 2'b11;
        t = 0;
        do begin
            cycle();
            t++;
        end while (!obs_v0 && t < 10);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("bp_vld", {31'd0, obs_v0}, 32'd1);
            chk("bp_s", {24'd0, obs_s}, 32'h77);
            chk("bp_c", {31'd0, obs_c}, 32'd0);
            chk("bp_req1_rdy", {31'd0, obs_r1}, 32'd0);
        end
        rsp0_rdy = 1;
        cycle();
        cycle();
        chk("bp_req1_granted", {31'd0, obs_r1}, 32'd1);
        req1_vld = 0;
        for (int i = 0; i < 4; i++) cycle();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 500; i++) begin
            rst_n    = ($urandom_range(0, 249) != 0);
            req0_vld = $urandom_range(0, 1) == 1;
            req1_vld = $urandom_range(0, 1) == 1;
            rsp0_rdy = $urandom_range(0, 2) != 0;
            rsp1_rdy = $urandom_range(0, 2) != 0;
            req0_a   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            req0_b   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            req1_a   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            req1_b   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            req0_op  = 2'($urandom);
            req1_op  = 2'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 8-bit ALU between two requesters. Each request carries two operands and a 2-bit opcode; the block arbitrates round-robin, executes the operation on the ALU, and returns a registered result and carry to the winning requester over a valid/ready response channel. It sits between two client engines and the single ALU instance, which it instantiates internally.

## Interface
- CNT_W, 16: width of the completed-operation counter.

- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- req0_vld_i / req1_vld_i  in  1  request valid, requester 0 / 1
- req0_rdy_o / req1_rdy_o  out  1  request accepted this cycle
- req0_a_i / req1_a_i  in  8  operand A
- req0_b_i / req1_b_i  in  8  operand B
- req0_op_i / req1_op_i  in  2  opcode: 00 add, 01 sub, 10 decrement A, 11 xor
- rsp0_vld_o / rsp1_vld_o  out  1  result valid for requester 0 / 1
- rsp0_rdy_i / rsp1_rdy_i  in  1  requester consumes result
- rsp_s_o  out  8  result byte, shared by both response channels
- rsp_c_o  out  1  carry; ALU carry for add/sub, 0 for dec/xor
- busy_o  out  1  high in EXEC and RESP
- ops_cnt_o  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no valid request, stay.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one not granted last (rr_last).
  - reqN_rdy_o for the winner is asserted combinationally that cycle; the handshake is vld&rdy.
  - On handshake, latch a, b, op and the grant id into operand registers; go to EXEC.
- EXEC:
  - The ALU evaluates the latched operands.
  - Capture the result byte and carry into the result registers; go to RESP.
- RESP:
  - rspN_vld_o is high for the granted id only; rsp_s_o and rsp_c_o hold stable.
  - On rspN_vld_o & rspN_rdy_i: increment ops_cnt_o, set rr_last to the granted id, go to IDLE.
  - Otherwise stay; stalls are unbounded.
- Arithmetic:
  - Add: s = (a+b)[7:0], c = bit 8.
  - Sub: s = (a-b)[7:0], c is the ALU sub carry passed unchanged.
  - Dec: s = (a-1)[7:0], c = 0.
  - Xor: s = a^b, c = 0.
  - The b operand is ignored for dec.
- Reset values:
  - Outputs: all rdy/vld outputs 0, rsp_s_o 0x00, rsp_c_o 0, busy_o 0, ops_cnt_o 0.
  - Internal: FSM in IDLE, rr_last = 1, so requester 0 wins first contention.
- Boundary conditions:
  - No rdy is asserted outside IDLE. A requester holding vld waits.
  - A requester may drop vld before its handshake with no effect.
  - The response handshake and a new request in the same cycle: the request is not accepted until the next IDLE cycle.
  - Reset in EXEC or RESP discards the pending operation; no response is issued.
  - ops_cnt_o wraps from all-ones to 0.
  - rspN_rdy_i for the non-granted id is ignored.

## Timing
- Request accepted on edge N (handshake in cycle N-1 → operands registered at N).
- Result is captured at edge N+1; rsp_vld high from N+1 onward.
- With rsp_rdy held high, the response completes at edge N+2.
- The next accept is possible in the cycle after the response completes.
- Minimum spacing is 3 cycles per operation; maximum throughput is 1 op / 3 cycles.
- Outputs are registered except reqN_rdy_o, which is combinational from vld, state and rr_last.
- No combinational path from rsp_rdy to any output other than through state.

## Test plan
- Single add, requester 0: a=0xF0, b=0x20, op=00, rsp0_rdy=1 → rsp0_vld after 2 edges, rsp_s_o=0x10, rsp_c_o=1, ops_cnt_o=1, rsp1_vld never high.
- Dec and xor, requester 1:
  - a=0x00, op=10 → s=0xFF, c=0.
  - Then a=0xA5, b=0x0F, op=11 → s=0xAA, c=0; ops_cnt_o=2.
- Contention: both vld held high from reset, four transactions → grant order 0,1,0,1. Responses arrive on the matching rsp channel. The losing rdy is never asserted while the other is granted.
- Backpressure: rsp0_rdy low for 10 cycles → rsp0_vld, rsp_s_o and rsp_c_o are stable; req1_rdy stays 0 with req1_vld high. When rsp0_rdy rises, requester 1 is granted in the following IDLE cycle.
- Reset mid-operation: assert rst_n_i low during EXEC → all outputs return to reset values immediately. After release, no stale response appears. The first contention goes to requester 0.
- Counter wrap: CNT_W=2, five completed ops → ops_cnt_o sequence 1,2,3,0,1.
